// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, side/direction constants and score width for the pong game logic.
package pong_pkg;
   typedef enum logic [1:0] {SERVE, RALLY, POINT, GAME_OVER} state_t;
   localparam logic LEFT = 1'b0;
   localparam logic RIGHT = 1'b1;
   localparam int SCORE_W = 4;
endpackage

// File: rtl/pong_ball_ctrl_if.sv
// pong_ball_ctrl_if: tick/button inputs and LED/score outputs between the game logic and its neighbours.
interface pong_ball_ctrl_if #(parameter int N_LEDS = 8);
   import pong_pkg::*;
   logic tick;
   logic btn_l;
   logic btn_r;
   logic [N_LEDS-1:0] led;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic game_over;
   modport master (output tick, btn_l, btn_r, input led, score_l, score_r, game_over);
   modport slave (input tick, btn_l, btn_r, output led, score_l, score_r, game_over);
endinterface

// File: rtl/pos_to_led.sv
// pos_to_led: combinational one-hot decode of a ball position onto the LED row.
module pos_to_led #(parameter int N_LEDS = 8) (
   input  logic [$clog2(N_LEDS)-1:0] pos,
   output logic [N_LEDS-1:0]         led
);
   assign led = N_LEDS'(1) << pos;
endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: moves the ball one LED per tick, resolves end-zone hits and misses, keeps score.
module pong_ball_ctrl import pong_pkg::*; #(
   parameter int N_LEDS      = 8,
   parameter int WIN_SCORE   = 9,
   parameter int POINT_TICKS = 3
) (
   input logic             clk,
   input logic             reset,
   pong_ball_ctrl_if.slave bus
);
   localparam int PW = $clog2(N_LEDS);
   localparam int CW = $clog2(POINT_TICKS + 1);
   localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   localparam logic [CW-1:0] PT = CW'(POINT_TICKS);
   state_t state, state_n;
   logic [PW-1:0] pos, pos_n;
   logic dir, dir_n, server, server_n, hit_pend, hit_pend_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [SCORE_W-1:0] sl, sl_n, sr, sr_n;
   logic [N_LEDS-1:0] onehot_n, led_q;
   logic go_q, at_end, hit_btn, serve_btn;
   assign at_end = (dir == RIGHT) ? (pos == LAST) : (pos == '0);
   assign hit_btn = (dir == RIGHT) ? bus.btn_r : bus.btn_l;
   assign serve_btn = (server == RIGHT) ? bus.btn_r : bus.btn_l;
   always_comb begin
      state_n = state;
      pos_n = pos;
      dir_n = dir;
      server_n = server;
      hit_pend_n = hit_pend;
      cnt_n = cnt;
      sl_n = sl;
      sr_n = sr;
      case (state)
         SERVE: if (serve_btn) begin
            state_n = RALLY;
            dir_n = ~server;
         end
         RALLY: if (bus.tick && !at_end) begin
            pos_n = (dir == RIGHT) ? pos + 1'b1 : pos - 1'b1;
         end else if (bus.tick && (hit_pend || hit_btn)) begin
            dir_n = ~dir;
            pos_n = (dir == RIGHT) ? pos - 1'b1 : pos + 1'b1;
            hit_pend_n = 1'b0;
         end else if (bus.tick) begin
            // the player on the end the ball was heading to missed and serves next
            sl_n = (dir == RIGHT && sl < WIN) ? sl + 1'b1 : sl;
            sr_n = (dir == LEFT && sr < WIN) ? sr + 1'b1 : sr;
            server_n = dir;
            cnt_n = '0;
            state_n = POINT;
         end else if (at_end && hit_btn) begin
            hit_pend_n = 1'b1;
         end
         POINT: if (bus.tick) begin
            if (cnt + 1'b1 == PT) begin
               cnt_n = '0;
               state_n = (sl == WIN || sr == WIN) ? GAME_OVER : SERVE;
               pos_n = (server == RIGHT) ? LAST : '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAME_OVER: ;
      endcase
   end
   pos_to_led #(.N_LEDS(N_LEDS)) u_dec (.pos(pos_n), .led(onehot_n));
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SERVE;
         pos <= '0;
         dir <= RIGHT;
         server <= LEFT;
         hit_pend <= 1'b0;
         cnt <= '0;
         sl <= '0;
         sr <= '0;
         led_q <= N_LEDS'(1);
         go_q <= 1'b0;
      end else begin
         state <= state_n;
         pos <= pos_n;
         dir <= dir_n;
         server <= server_n;
         hit_pend <= hit_pend_n;
         cnt <= cnt_n;
         sl <= sl_n;
         sr <= sr_n;
         led_q <= (state_n == POINT) ? '1 : (state_n == GAME_OVER) ? '0 : onehot_n;
         go_q <= (state_n == GAME_OVER);
      end
   end
   assign bus.led = led_q;
   assign bus.score_l = sl;
   assign bus.score_r = sr;
   assign bus.game_over = go_q;
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed game scenarios checked every cycle against a behavioural model plus literal pins.
module tb_pong_ball_ctrl;
   localparam int N = 4;
   localparam int W = 2;
   localparam int PT = 2;
   localparam int M_SERVE = 0, M_RALLY = 1, M_POINT = 2, M_OVER = 3;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   pong_ball_ctrl_if #(.N_LEDS(N)) bus();
   pong_ball_ctrl #(.N_LEDS(N), .WIN_SCORE(W), .POINT_TICKS(PT)) dut (.clk(clk), .reset(reset), .bus(bus));
   int n_cmp = 0;
   int n_bad = 0;
   bit armed = 1'b0;
   int m_mode = M_SERVE, m_pos = 0, m_vel = 1, m_srv = 0, m_pend = 0, m_cnt = 0, m_sl = 0, m_sr = 0;
   // ball kinematics as position plus a signed velocity of +1/-1
   always @(posedge clk) begin : model
      int mo, p, v, s, pe, c, l, r, e, b;
      mo = m_mode; p = m_pos; v = m_vel; s = m_srv; pe = m_pend; c = m_cnt; l = m_sl; r = m_sr;
      if (reset) begin
         mo = M_SERVE; p = 0; v = 1; s = 0; pe = 0; c = 0; l = 0; r = 0;
      end else if (mo == M_SERVE) begin
         if ((s == 0 && bus.btn_l) || (s == 1 && bus.btn_r)) begin
            mo = M_RALLY;
            v = (s == 0) ? 1 : -1;
         end
      end else if (mo == M_RALLY) begin
         e = (v > 0) ? N - 1 : 0;
         b = (v > 0) ? int'(bus.btn_r) : int'(bus.btn_l);
         if (bus.tick) begin
            if (p != e) p = p + v;
            else if (pe != 0 || b != 0) begin
               v = -v; p = p + v; pe = 0;
            end else begin
               if (v > 0) l = (l + 1 > W) ? W : l + 1;
               else r = (r + 1 > W) ? W : r + 1;
               s = (v > 0) ? 1 : 0;
               c = 0;
               mo = M_POINT;
            end
         end else if (p == e && b != 0) pe = 1;
      end else if (mo == M_POINT) begin
         if (bus.tick) begin
            c = c + 1;
            if (c == PT) begin
               c = 0;
               if (l == W || r == W) mo = M_OVER;
               else begin
                  mo = M_SERVE;
                  p = (s == 1) ? N - 1 : 0;
               end
            end
         end
      end
      m_mode <= mo; m_pos <= p; m_vel <= v; m_srv <= s; m_pend <= pe; m_cnt <= c; m_sl <= l; m_sr <= r;
   end
   function automatic int exp_led();
      return (m_mode == M_POINT) ? (1 << N) - 1 : (m_mode == M_OVER) ? 0 : (1 << m_pos);
   endfunction
   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (armed) begin
         check("model_led", int'(bus.led), exp_led());
         check("model_score_l", int'(bus.score_l), m_sl);
         check("model_score_r", int'(bus.score_r), m_sr);
         check("model_game_over", int'(bus.game_over), int'(m_mode == M_OVER));
      end
   end
   task automatic cyc(input logic t, input logic bl, input logic br);
      bus.tick = t; bus.btn_l = bl; bus.btn_r = br;
      @(posedge clk);
      #1;
      bus.tick = 1'b0; bus.btn_l = 1'b0; bus.btn_r = 1'b0;
   endtask
   task automatic tk();
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
   endtask
   task automatic outs(input string nm, input int led, input int sl, input int sr, input int go);
      check({nm, "_led"}, int'(bus.led), led);
      check({nm, "_score_l"}, int'(bus.score_l), sl);
      check({nm, "_score_r"}, int'(bus.score_r), sr);
      check({nm, "_game_over"}, int'(bus.game_over), go);
   endtask
   initial begin
      bus.tick = 1'b0; bus.btn_l = 1'b0; bus.btn_r = 1'b0;
      reset = 1'b1;
      cyc(0, 0, 0); cyc(0, 0, 0);
      reset = 1'b0;
      armed = 1'b1;
      outs("reset", 'b0001, 0, 0, 0);
      repeat (10) tk();
      outs("idle_ticks", 'b0001, 0, 0, 0);
      cyc(0, 0, 1); tk();
      outs("serve_btn_r_ignored", 'b0001, 0, 0, 0);
      cyc(0, 1, 0);
      tk(); outs("rally_p1", 'b0010, 0, 0, 0);
      tk(); tk(); outs("rally_p3", 'b1000, 0, 0, 0);
      cyc(0, 0, 1); tk();
      outs("hit_right", 'b0100, 0, 0, 0);
      tk(); tk(); outs("rally_p0", 'b0001, 0, 0, 0);
      cyc(0, 1, 0); tk();
      outs("hit_left", 'b0010, 0, 0, 0);
      tk(); tk(); tk();
      outs("miss_right", 'b1111, 1, 0, 0);
      tk(); outs("point_hold", 'b1111, 1, 0, 0);
      tk(); outs("serve_right", 'b1000, 1, 0, 0);
      cyc(0, 1, 0); tk();
      outs("serve_btn_l_ignored", 'b1000, 1, 0, 0);
      cyc(0, 0, 1);
      tk(); tk(); tk(); outs("rally_left_p0", 'b0001, 1, 0, 0);
      cyc(0, 1, 0); tk(); tk(); tk();
      repeat (4) cyc(0, 0, 0);
      cyc(1, 0, 1);
      outs("same_cycle_hit", 'b0100, 1, 0, 0);
      tk(); tk(); cyc(0, 1, 0); tk(); tk();
      outs("at_p2", 'b0100, 1, 0, 0);
      cyc(0, 0, 1);
      repeat (4) cyc(0, 0, 0);
      cyc(1, 0, 1);
      outs("entry_press_p3", 'b1000, 1, 0, 0);
      tk();
      outs("early_press_miss", 'b1111, 2, 0, 0);
      tk(); tk();
      outs("game_over", 'b0000, 2, 0, 1);
      tk(); cyc(0, 1, 1); cyc(1, 1, 1); tk();
      outs("game_over_hold", 'b0000, 2, 0, 1);
      reset = 1'b1; cyc(0, 0, 0); reset = 1'b0;
      outs("reset_from_over", 'b0001, 0, 0, 0);
      cyc(0, 1, 0); tk(); tk(); tk();
      cyc(0, 0, 1); tk(); tk(); tk(); tk();
      outs("miss_left", 'b1111, 0, 1, 0);
      tk(); tk();
      outs("serve_left_again", 'b0001, 0, 1, 0);
      cyc(0, 1, 0); tk(); tk();
      outs("mid_rally", 'b0100, 0, 1, 0);
      reset = 1'b1; cyc(0, 1, 1); reset = 1'b0;
      outs("reset_mid_rally", 'b0001, 0, 0, 0);
      cyc(0, 1, 0); tk();
      outs("serve_after_reset", 'b0010, 0, 0, 0);
      repeat (3) cyc(0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Game-logic stage directly downstream of the game tick generator.
- Consumes its single-cycle tick pulse and two player button pulses.
- Moves the ball one LED position per tick along an N-LED row, resolves hits and misses, and keeps score.
- Drives the LED row and the score outputs for the display stage.

Parameters:
- N_LEDS, 8, number of ball positions (LEDs); legal range 4..16.
- WIN_SCORE, 9, points that end the game; legal range 1..15.
- POINT_TICKS, 3, ticks the all-LEDs-on point indication is held after a miss.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- tick  in  1  one-cycle pulse from the tick generator; the game advances on it.
- btn_l  in  1  left-player press; already debounced; one-cycle pulse.
- btn_r  in  1  right-player press; already debounced; one-cycle pulse.
- led  out  N_LEDS  ball display; bit 0 is the left end.
- score_l  out  4  left-player score.
- score_r  out  4  right-player score.
- game_over  out  1  high once either score equals WIN_SCORE.

Behaviour:
- One clock; synchronous active-high reset; all state changes on posedge clk.
- Reset values: state SERVE, pos=0, dir=RIGHT, server=LEFT, hit_pend=0, point_cnt=0, score_l=0, score_r=0, game_over=0, led=one-hot(0).
- Reset has priority over every other input, including mid-rally and in GAME_OVER.

States:
- SERVE
  - Ball parked at the server's end: pos=0 for LEFT, pos=N_LEDS-1 for RIGHT.
  - led=one-hot(pos).
  - The server's button enters RALLY with dir pointing away from the server.
  - The other player's button is ignored; ticks are ignored.
  - The ball first moves on the next tick after the press.
- RALLY
  - On tick, if the ball is not at the far end in dir: pos moves one step in dir.
  - End-zone hit window:
    - While pos==N_LEDS-1 with dir=RIGHT, btn_r sets hit_pend.
    - While pos==0 with dir=LEFT, btn_l sets hit_pend.
    - Presses at any other position, or by the other player, are ignored.
  - On tick at the end position:
    - If hit_pend (or the correct button arrives in the same cycle as the tick): dir flips, pos steps one toward the centre, hit_pend clears.
    - Otherwise: miss. The opponent's score increments, server is set to the player who missed, point_cnt=0, and the state goes to POINT.
  - Simultaneous tick and button at the end: counts as a hit.
  - A press in the same cycle as the tick that moves the ball into the end zone does not count.
- POINT
  - led = all ones.
  - point_cnt increments on each tick.
  - When point_cnt reaches POINT_TICKS: if either score equals WIN_SCORE, go to GAME_OVER; otherwise go to SERVE with pos at the server's end.
- GAME_OVER
  - led = all zeros, game_over=1.
  - Scores are held.
  - All inputs are ignored until reset.

Arithmetic and timing:
- Scores are 4-bit and never exceed WIN_SCORE (compare before increment).
- pos is $clog2(N_LEDS) bits; it never wraps.
- point_cnt is wide enough for POINT_TICKS.
- Outputs are registered and update the cycle after the causing event.
- Latency from tick to led change is 1 clk.

Decomposition:
- Package pong_pkg holds:
  - state enum {SERVE, RALLY, POINT, GAME_OVER};
  - side/direction constants LEFT=0 and RIGHT=1;
  - the score width constant SCORE_W=4.
- One sub-module, pos_to_led: a combinational decode of pos into one-hot led, parameterised by N_LEDS.
- Output override muxing (all on for POINT, all off for GAME_OVER) stays in the top level.

Test Plan:
All scenarios use N_LEDS=4, WIN_SCORE=2, POINT_TICKS=2, with tick pulsed every 5 clks.
1. Reset then idle ticks:
   - led=0001, scores 0/0.
   - 10 ticks without btn_l leave led=0001.
   - btn_r has no effect.
2. Serve and full rally:
   - btn_l, then ticks give led 0010, 0100, 1000.
   - btn_r pulsed before the next tick; on that tick led=0100 and dir is LEFT.
   - Ball returns to 0001; btn_l hits; rally continues.
3. Miss:
   - Ball reaches 1000 with no btn_r; next tick gives led=1111 and score_l=1.
   - After 2 ticks: led=1000 in SERVE (right player serves).
   - btn_l is ignored there.
4. Same-cycle tick and btn_r at pos 3:
   - Counts as a hit; led=0100 next cycle; no score change.
   - btn_r pressed at pos 2 and never again: the ball is missed.
5. Game over:
   - Left wins two points; after POINT, game_over=1, led=0000, score_l=2.
   - Further ticks and buttons change nothing.
6. Reset mid-rally:
   - Assert reset with the ball at 0100 and score_r=1.
   - Next cycle: led=0001, both scores 0, state SERVE, game_over=0.
